front_end: RTL and testbench
============================

# front_end

Request front end of the memory controller, between the host request port and the 16 per-bank schedulers. It decodes each accepted host request into bank, row and column fields and tags it with a unique in-flight index. It presents the request to the target bank through a valid/ready handshake. It also turns back-end completions into read/write done pulses toward the host, and applies back-pressure when indices, write credits or bank staging slots are exhausted.

## Interface
- READ, 1'b0, encoding of a read in request/completion type fields
- WRITE, 1'b1, encoding of a write
- RA_POS, 10, LSB position of the row field in the address
- CA, 10, column address width (address bits [CA-1:0])
- RA, 16, row address width (bits [RA_POS+RA-1:RA_POS])
- DQ, 16, data width
- IDX, 6, index width; 2^IDX in-flight requests
- WR_FIFO_SIZE, 2, and WR_FIFO_NUM, 3: outstanding-write limit is WR_FIFO_SIZE*WR_FIFO_NUM (6)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset; synchronous and active-high (the name is kept from the codebase; asserted = 1)
- in_valid  in  1  host request valid
- in_request_type  in  1  READ/WRITE
- in_request_data  in  DQ  write data
- in_request_address  in  RA_POS+RA+4  address; bank = top 4 bits
- out_busy  out  1  back-pressure; the request is not accepted while high
- request_done_valid  in  1  back-end completion strobe
- the_type  in  1  completion type (r_type)
- data_in  in  DQ  read data of the completion
- index  in  IDX  index of the completing request
- write_done  out  1  write completion pulse
- read_done  out  1  read completion pulse
- data_out  out  DQ  read data to host
- ready  in  16  per-bank ready
- valid_o  out  16  per-bank request valid
- dq_o, idx_o, ra_o, ca_o  out  16×DQ, 16×IDX, 16×RA, 16×CA  per-bank request fields
- t_o  out  16  per-bank request type

## Operation
- Acceptance: a request is accepted when in_valid=1 and out_busy=0.
- out_busy (combinational) is high if any of the following holds:
  - the free-index vector is all zeros;
  - the request is a write and outstanding writes = WR_FIFO_SIZE*WR_FIFO_NUM;
  - the target bank stage is occupied and not draining (valid_o[b]=1 and ready[b]=0).
- Decode: bank b = address MSBs [RA_POS+RA+3:RA_POS+RA]; ra = address[RA_POS+RA-1:RA_POS]; ca = address[CA-1:0].
- Index allocation:
  - The index is the lowest-numbered free entry of a 2^IDX free vector.
  - On acceptance the entry is marked busy; writes increment the outstanding-write counter.
- Bank stage: one register per bank holds dq/idx/ra/ca/type plus valid_o[b].
  - The stage loads on acceptance.
  - It clears on valid_o[b]&ready[b] unless it is reloaded in the same cycle.
- Completion: on request_done_valid=1, index is freed.
  - If the_type=READ: read_done=1 and data_out=data_in, both registered (one cycle later).
  - If the_type=WRITE: write_done=1 and the outstanding-write counter decrements.
  - A completion for an index not currently busy is ignored: no pulse, no counter change.
- Outputs are held while stalled. dq_o/idx_o/ra_o/ca_o/t_o are don't-care-stable (retain their last value) when valid_o=0.

## Timing
- Reset: valid_o, read_done, write_done, data_out, out_busy-related state, the outstanding-write counter, and all per-bank fields are 0. All indices are free.
- Acceptance at edge N → valid_o[b]=1 with the request fields from N+1.
- Transfer at the edge where valid_o[b]&ready[b] → valid_o[b]=0 at the next cycle, unless a new request to bank b is accepted at that same edge (back-to-back, no bubble).
- Completion at edge N → read_done/write_done high for exactly cycle N+1. Back-to-back completions give consecutive pulses.
- Same-edge allocate and free: allocation uses the pre-edge free vector, so the freed index is reusable from the next cycle. The write counter handles simultaneous increment and decrement as net zero.
- Reset asserted mid-operation discards all staged requests and in-flight state at that edge.

## Test plan
- Reset, then 30 random requests with ready=0 → at most one request staged per bank; out_busy=1 for a second request to an occupied bank; idx_o values unique, starting at 0.
- Set ready[1]=1 with a continuous stream to bank 1 → one transfer per cycle, valid_o[1] continuously high, idx_o incrementing 0,1,2…
- 7 writes with no completions and all ready=1 → the first 6 are accepted, and out_busy=1 on the 7th. One WRITE completion → the 7th is accepted next cycle, and write_done pulses once.
- 64 reads with no completions → out_busy=1 on the 65th. READ completion with index=5 and data_in=16'hA5A5 → read_done=1 and data_out=A5A5 one cycle later; the next request gets idx 5.
- Completion for a never-allocated index → no read_done/write_done; the free vector is unchanged.
- Reset asserted while banks hold requests → all valid_o=0 the next cycle; the next accepted request gets idx 0.

Source files
------------

// File: rtl/front_end.sv
// rtl/front_end.sv - host request decode, index allocation, per-bank staging and completion pulses
module front_end #(
    parameter logic READ         = 1'b0,
    parameter logic WRITE        = 1'b1,
    parameter int   RA_POS       = 10,
    parameter int   CA           = 10,
    parameter int   RA           = 16,
    parameter int   DQ           = 16,
    parameter int   IDX          = 6,
    parameter int   WR_FIFO_SIZE = 2,
    parameter int   WR_FIFO_NUM  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_request_type,
    input  logic [DQ-1:0]            in_request_data,
    input  logic [RA_POS+RA+3:0]     in_request_address,
    output logic                     out_busy,
    input  logic                     request_done_valid,
    input  logic                     the_type,
    input  logic [DQ-1:0]            data_in,
    input  logic [IDX-1:0]           index,
    output logic                     write_done,
    output logic                     read_done,
    output logic [DQ-1:0]            data_out,
    input  logic [15:0]              ready,
    output logic [15:0]              valid_o,
    output logic [15:0][DQ-1:0]      dq_o,
    output logic [15:0][IDX-1:0]     idx_o,
    output logic [15:0][RA-1:0]      ra_o,
    output logic [15:0][CA-1:0]      ca_o,
    output logic [15:0]              t_o
);
    localparam int AW     = RA_POS + RA + 4;
    localparam int NIDX   = 1 << IDX;
    localparam int WR_MAX = WR_FIFO_SIZE * WR_FIFO_NUM;
    localparam int CW     = $clog2(WR_MAX + 1);

    logic [NIDX-1:0] busy_q;
    logic [NIDX-1:0] busy_d;
    logic [CW-1:0]   wr_cnt;
    logic [IDX-1:0]  alloc_idx;
    logic [3:0]      bank;
    logic [RA-1:0]   req_ra;
    logic [CA-1:0]   req_ca;
    logic            accept;
    logic            done_ok;
    logic            wr_inc;
    logic            wr_dec;

    assign bank   = in_request_address[AW-1 -: 4];
    assign req_ra = in_request_address[RA_POS+RA-1:RA_POS];
    assign req_ca = in_request_address[CA-1:0];

    // Lowest free entry wins; scanning downward leaves the smallest index last.
    always_comb begin
        alloc_idx = '0;
        for (int i = NIDX - 1; i >= 0; i--) begin
            if (!busy_q[i]) alloc_idx = IDX'(i);
        end
    end

    assign out_busy = (&busy_q)
                    | ((in_request_type == WRITE) && (wr_cnt == CW'(WR_MAX)))
                    | (valid_o[bank] & ~ready[bank]);
    assign accept   = in_valid & ~out_busy;
    // Completions for indices that are not in flight are dropped entirely.
    assign done_ok  = request_done_valid & busy_q[index];
    assign wr_inc   = accept & (in_request_type == WRITE);
    assign wr_dec   = done_ok & (the_type == WRITE);

    // Allocation looks at the pre-edge vector, so a same-edge free never collides.
    always_comb begin
        busy_d = busy_q;
        if (done_ok) busy_d[index] = 1'b0;
        if (accept)  busy_d[alloc_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            busy_q     <= '0;
            wr_cnt     <= '0;
            read_done  <= 1'b0;
            write_done <= 1'b0;
            data_out   <= '0;
        end else begin
            busy_q     <= busy_d;
            read_done  <= done_ok & (the_type == READ);
            write_done <= wr_dec;
            if (done_ok && (the_type == READ)) data_out <= data_in;
            case ({wr_inc, wr_dec})
                2'b10:   wr_cnt <= wr_cnt + 1'b1;
                2'b01:   wr_cnt <= wr_cnt - 1'b1;
                default: wr_cnt <= wr_cnt;
            endcase
        end
    end

    // A reload at the transfer edge keeps valid_o high with no bubble.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid_o <= '0;
            dq_o    <= '0;
            idx_o   <= '0;
            ra_o    <= '0;
            ca_o    <= '0;
            t_o     <= '0;
        end else begin
            for (int b = 0; b < 16; b++) begin
                if (accept && (bank == 4'(b))) begin
                    valid_o[b] <= 1'b1;
                    dq_o[b]    <= in_request_data;
                    idx_o[b]   <= alloc_idx;
                    ra_o[b]    <= req_ra;
                    ca_o[b]    <= req_ca;
                    t_o[b]     <= in_request_type;
                end else if (ready[b]) begin
                    valid_o[b] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_front_end.sv
// tb/tb_front_end.sv - directed self-checking bench for front_end
module tb_front_end;
    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_request_type;
    logic [15:0]       in_request_data;
    logic [29:0]       in_request_address;
    logic              out_busy;
    logic              request_done_valid;
    logic              the_type;
    logic [15:0]       data_in;
    logic [5:0]        index;
    logic              write_done;
    logic              read_done;
    logic [15:0]       data_out;
    logic [15:0]       ready;
    logic [15:0]       valid_o;
    logic [15:0][15:0] dq_o;
    logic [15:0][5:0]  idx_o;
    logic [15:0][15:0] ra_o;
    logic [15:0][9:0]  ca_o;
    logic [15:0]       t_o;

    int n_assert = 0;
    int n_fail   = 0;
    int nidx;

    always #5 clk = ~clk;

    front_end dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_request_type    (in_request_type),
        .in_request_data    (in_request_data),
        .in_request_address (in_request_address),
        .out_busy           (out_busy),
        .request_done_valid (request_done_valid),
        .the_type           (the_type),
        .data_in            (data_in),
        .index              (index),
        .write_done         (write_done),
        .read_done          (read_done),
        .data_out           (data_out),
        .ready              (ready),
        .valid_o            (valid_o),
        .dq_o               (dq_o),
        .idx_o              (idx_o),
        .ra_o               (ra_o),
        .ca_o               (ca_o),
        .t_o                (t_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic t, input logic [3:0] b, input logic [15:0] r,
                       input logic [9:0] c, input logic [15:0] d);
        in_valid           = 1'b1;
        in_request_type    = t;
        in_request_address = {b, r, c};
        in_request_data    = d;
        #1;
    endtask

    task automatic complete(input logic t, input logic [5:0] i, input logic [15:0] d);
        request_done_valid = 1'b1;
        the_type           = t;
        index              = i;
        data_in            = d;
    endtask

    initial begin
        rst_n              = 1'b1;
        in_valid           = 1'b0;
        in_request_type    = READ;
        in_request_data    = '0;
        in_request_address = '0;
        request_done_valid = 1'b0;
        the_type           = READ;
        data_in            = '0;
        index              = '0;
        ready              = '0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_valid_o", valid_o, 0);
        check("rst_read_done", read_done, 0);
        check("rst_write_done", write_done, 0);
        check("rst_data_out", data_out, 0);
        check("rst_out_busy", out_busy, 0);
        check("rst_dq0", dq_o[0], 0);

        // Stage one request per bank while nothing drains.
        req(READ, 4'd3, 16'h1234, 10'h155, 16'hBEEF);
        check("first_busy", out_busy, 0);
        tick();
        check("first_valid", valid_o, 16'h0008);
        check("first_idx", idx_o[3], 0);
        check("first_ra", ra_o[3], 16'h1234);
        check("first_ca", ca_o[3], 10'h155);
        check("first_dq", dq_o[3], 16'hBEEF);
        check("first_t", t_o[3], READ);
        req(READ, 4'd3, 16'h0001, 10'h001, 16'h0001);
        check("occupied_bank_busy", out_busy, 1);
        req(WRITE, 4'd5, 16'hABCD, 10'h3FF, 16'h0F0F);
        check("other_bank_busy", out_busy, 0);
        tick();
        check("second_valid", valid_o, 16'h0028);
        check("second_idx", idx_o[5], 1);
        check("second_t", t_o[5], WRITE);
        check("held_ra3", ra_o[3], 16'h1234);
        nidx = 2;
        for (int b = 0; b < 16; b++) begin
            if (b != 3 && b != 5) begin
                req(READ, 4'(b), 16'(b * 3), 10'(b), 16'(b));
                tick();
                check("fill_idx", idx_o[b], 64'(nidx));
                nidx++;
            end
        end
        check("fill_valid", valid_o, 16'hFFFF);
        req(READ, 4'd9, 16'h0, 10'h0, 16'h0);
        check("fill_busy", out_busy, 1);
        in_valid = 1'b0;

        // Reset with every bank staged.
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        check("midrst_valid", valid_o, 0);

        // Continuous stream into a draining bank.
        ready = 16'h0002;
        for (int k = 0; k < 5; k++) begin
            req(READ, 4'd1, 16'h0, 10'(k), 16'h0);
            check("stream_busy", out_busy, 0);
            tick();
            check("stream_valid", valid_o[1], 1);
            check("stream_idx", idx_o[1], 64'(k));
            check("stream_ca", ca_o[1], 64'(k));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", valid_o[1], 0);

        // Read completion and reuse of the freed index.
        complete(READ, 6'd2, 16'h1357);
        tick();
        request_done_valid = 1'b0;
        check("rd_done", read_done, 1);
        check("rd_data", data_out, 16'h1357);
        check("rd_no_wr", write_done, 0);
        tick();
        check("rd_pulse_end", read_done, 0);
        ready = 16'hFFFF;
        req(READ, 4'd7, 16'h0, 10'h0, 16'h0);
        tick();
        check("reuse_idx", idx_o[7], 2);
        in_valid = 1'b0;

        // Completions for indices never allocated.
        complete(READ, 6'd40, 16'hDEAD);
        tick();
        request_done_valid = 1'b0;
        check("bogus_rd_done", read_done, 0);
        check("bogus_rd_data", data_out, 16'h1357);
        complete(WRITE, 6'd41, 16'h0);
        tick();
        request_done_valid = 1'b0;
        check("bogus_wr_done", write_done, 0);
        req(READ, 4'd7, 16'h0, 10'h0, 16'h0);
        tick();
        check("after_bogus_idx", idx_o[7], 5);

        // Outstanding-write limit.
        for (int k = 0; k < 6; k++) begin
            req(WRITE, 4'(8 + k), 16'h0, 10'h0, 16'(k));
            check("wr_busy", out_busy, 0);
            tick();
            check("wr_idx", idx_o[8 + k], 64'(6 + k));
        end
        req(WRITE, 4'd14, 16'h0, 10'h0, 16'h7777);
        check("wr_limit_busy", out_busy, 1);
        req(READ, 4'd14, 16'h0, 10'h0, 16'h7777);
        check("wr_limit_read_ok", out_busy, 0);
        req(WRITE, 4'd14, 16'h0, 10'h0, 16'h7777);
        complete(WRITE, 6'd6, 16'h0);
        tick();
        request_done_valid = 1'b0;
        check("wr_done", write_done, 1);
        check("wr_done_no_rd", read_done, 0);
        check("wr_after_free_busy", out_busy, 0);
        tick();
        check("wr7_valid", valid_o[14], 1);
        check("wr7_idx", idx_o[14], 6);
        check("wr_pulse_end", write_done, 0);
        req(WRITE, 4'd15, 16'h0, 10'h0, 16'h0);
        check("wr_limit_again", out_busy, 1);

        // Exhaust all 64 indices.
        for (int k = 0; k < 52; k++) begin
            req(READ, 4'd0, 16'h0, 10'(k), 16'h0);
            tick();
            check("fill64_idx", idx_o[0], 64'(12 + k));
        end
        req(READ, 4'd0, 16'h0, 10'h0, 16'h0);
        check("idx_full_busy", out_busy, 1);
        complete(READ, 6'd5, 16'hA5A5);
        tick();
        request_done_valid = 1'b0;
        check("full_rd_done", read_done, 1);
        check("full_rd_data", data_out, 16'hA5A5);
        check("full_freed_busy", out_busy, 0);
        tick();
        check("full_reuse_idx", idx_o[0], 5);
        check("full_again_busy", out_busy, 1);
        in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
